// File: rtl/ciq_entry_array_pkg.sv
// Shared definitions for the compacting-free issue queue entry array.
// Holds the sizing constants, the per-entry state record and two small
// helpers: a lowest-set-bit encoder used to pick the allocation slot, and a
// wake-up tag comparator used both for resident entries and for the entry
// being written in the dispatch cycle.
package ciq_entry_array_pkg;

  localparam int ISSUE_NUM = 4;
  localparam int PRF_WIDTH = 6;
  localparam int CIQ_DEPTH = 16;
  localparam int FU_WIDTH  = 2;
  localparam int IDX_WIDTH = $clog2(CIQ_DEPTH);
  localparam int CNT_WIDTH = IDX_WIDTH + 1;

  typedef struct packed {
    logic                 valid;
    logic [PRF_WIDTH-1:0] prs1;
    logic                 r1;
    logic [PRF_WIDTH-1:0] prs2;
    logic                 r2;
    logic [PRF_WIDTH-1:0] prd;
    logic                 prd_v;
    logic [FU_WIDTH-1:0]  fu;
  } ciq_entry_t;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate on
  // a separate "any set" signal).
  function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [CIQ_DEPTH-1:0] v);
    lowest_set = '0;
    for (int i = CIQ_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_WIDTH'(i);
    end
  endfunction

  // True when any valid wake-up bus carries the given source tag.
  function automatic logic tag_hit(input logic [PRF_WIDTH-1:0]           src,
                                   input logic [ISSUE_NUM*PRF_WIDTH-1:0] tags,
                                   input logic [ISSUE_NUM-1:0]           vld);
    tag_hit = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (vld[j] && (tags[j*PRF_WIDTH +: PRF_WIDTH] == src)) tag_hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ciq_entry_array_entry.sv
// One issue-queue slot.
// Holds the dispatched instruction's sources, destination, target port and
// per-source ready bits; snoops every wake-up bus and raises a request on its
// own issue port once both sources are ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop the entry
//   alloc             write the dispatch fields into this slot this edge
//   free              entry was granted; invalidate at this edge
//   disp_*            dispatch payload (shared by all slots)
//   wake_tag/valid    wake-up broadcast buses
//   valid, prs1, prs2, prd, prd_v   registered entry contents
//   req               per-port issue request (registered state only)
module ciq_entry_array_entry
  import ciq_entry_array_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           alloc,
  input  logic                           free,
  input  logic [PRF_WIDTH-1:0]           disp_prs1,
  input  logic [PRF_WIDTH-1:0]           disp_prs2,
  input  logic                           disp_prs1_rdy,
  input  logic                           disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]           disp_prd,
  input  logic                           disp_prd_v,
  input  logic [FU_WIDTH-1:0]            disp_fu,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] wake_tag,
  input  logic [ISSUE_NUM-1:0]           wake_valid,
  output logic                           valid,
  output logic [PRF_WIDTH-1:0]           prs1,
  output logic [PRF_WIDTH-1:0]           prs2,
  output logic [PRF_WIDTH-1:0]           prd,
  output logic                           prd_v,
  output logic [ISSUE_NUM-1:0]           req
);

  ciq_entry_t ent;

  logic hit1;
  logic hit2;
  logic disp_hit1;
  logic disp_hit2;

  assign hit1      = tag_hit(ent.prs1, wake_tag, wake_valid);
  assign hit2      = tag_hit(ent.prs2, wake_tag, wake_valid);
  // Same-cycle broadcast compared against the incoming sources so a wake-up
  // coinciding with dispatch is not lost.
  assign disp_hit1 = tag_hit(disp_prs1, wake_tag, wake_valid);
  assign disp_hit2 = tag_hit(disp_prs2, wake_tag, wake_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (flush) begin
      ent.valid <= 1'b0;
      ent.r1    <= 1'b0;
      ent.r2    <= 1'b0;
    end else if (alloc) begin
      ent.valid <= 1'b1;
      ent.prs1  <= disp_prs1;
      ent.prs2  <= disp_prs2;
      ent.r1    <= disp_prs1_rdy | (disp_prs1 == '0) | disp_hit1;
      ent.r2    <= disp_prs2_rdy | (disp_prs2 == '0) | disp_hit2;
      ent.prd   <= disp_prd;
      ent.prd_v <= disp_prd_v;
      ent.fu    <= disp_fu;
    end else if (free) begin
      ent.valid <= 1'b0;
      ent.r1    <= 1'b0;
      ent.r2    <= 1'b0;
    end else if (ent.valid) begin
      // Ready bits are sticky until the entry is freed.
      if (hit1) ent.r1 <= 1'b1;
      if (hit2) ent.r2 <= 1'b1;
    end
  end

  always_comb begin
    req = '0;
    for (int p = 0; p < ISSUE_NUM; p++) begin
      req[p] = ent.valid & ent.r1 & ent.r2 & (ent.fu == FU_WIDTH'(p));
    end
  end

  assign valid = ent.valid;
  assign prs1  = ent.prs1;
  assign prs2  = ent.prs2;
  assign prd   = ent.prd;
  assign prd_v = ent.prd_v;

endmodule

// File: rtl/ciq_entry_array.sv
// Issue-queue entry array: consumer end of the wake-up tag broadcast.
// Allocates dispatched instructions into the lowest free slot, lets each slot
// snoop the wake-up buses, exposes per-port request vectors to the arbiters,
// frees granted slots and returns the granted slot's tags per port.
//
// Dispatch handshake: an instruction is accepted at a rising edge exactly when
// disp_valid && disp_ready && !flush; disp_ready depends only on registered
// state, so it never depends on disp_valid or on same-cycle grants.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        invalidate all entries
//   disp_valid / disp_ready      dispatch handshake
//   disp_prs1/2, disp_prs1/2_rdy source registers and rename-time readiness
//   disp_prd, disp_prd_v, disp_fu destination and target issue port
//   wake_tag, wake_valid         wake-up buses, bus j at [j*PRF_WIDTH +: PRF_WIDTH]
//   issue_req, grant             per-port vectors, port p at [p*CIQ_DEPTH +: CIQ_DEPTH]
//   arbit_grant/prd/prd_v/prs1/prs2  granted entry per port, zero when no grant
//   ciq_count                    number of valid entries
module ciq_entry_array
  import ciq_entry_array_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [PRF_WIDTH-1:0]           disp_prs1,
  input  logic [PRF_WIDTH-1:0]           disp_prs2,
  input  logic                           disp_prs1_rdy,
  input  logic                           disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]           disp_prd,
  input  logic                           disp_prd_v,
  input  logic [FU_WIDTH-1:0]            disp_fu,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] wake_tag,
  input  logic [ISSUE_NUM-1:0]           wake_valid,
  output logic [ISSUE_NUM*CIQ_DEPTH-1:0] issue_req,
  input  logic [ISSUE_NUM*CIQ_DEPTH-1:0] grant,
  output logic [ISSUE_NUM-1:0]           arbit_grant,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prd,
  output logic [ISSUE_NUM-1:0]           arbit_prd_v,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prs1,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prs2,
  output logic [CNT_WIDTH-1:0]           ciq_count
);

  logic [CIQ_DEPTH-1:0]           valid_vec;
  logic [CIQ_DEPTH-1:0]           prd_v_vec;
  logic [CIQ_DEPTH-1:0]           alloc_vec;
  logic [CIQ_DEPTH-1:0]           free_vec;
  logic [PRF_WIDTH-1:0]           e_prs1 [CIQ_DEPTH];
  logic [PRF_WIDTH-1:0]           e_prs2 [CIQ_DEPTH];
  logic [PRF_WIDTH-1:0]           e_prd  [CIQ_DEPTH];
  logic [ISSUE_NUM-1:0]           e_req  [CIQ_DEPTH];
  logic [ISSUE_NUM*CIQ_DEPTH-1:0] eff_grant;
  logic [IDX_WIDTH-1:0]           alloc_idx;
  logic                           accept;
  logic [CNT_WIDTH-1:0]           grant_cnt;
  logic [CNT_WIDTH-1:0]           count_q;

  for (genvar i = 0; i < CIQ_DEPTH; i++) begin : g_entry
    ciq_entry_array_entry u_entry (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .alloc         (alloc_vec[i]),
      .free          (free_vec[i]),
      .disp_prs1     (disp_prs1),
      .disp_prs2     (disp_prs2),
      .disp_prs1_rdy (disp_prs1_rdy),
      .disp_prs2_rdy (disp_prs2_rdy),
      .disp_prd      (disp_prd),
      .disp_prd_v    (disp_prd_v),
      .disp_fu       (disp_fu),
      .wake_tag      (wake_tag),
      .wake_valid    (wake_valid),
      .valid         (valid_vec[i]),
      .prs1          (e_prs1[i]),
      .prs2          (e_prs2[i]),
      .prd           (e_prd[i]),
      .prd_v         (prd_v_vec[i]),
      .req           (e_req[i])
    );
  end

  // Only slots invalid in the current registered state are eligible, so a
  // slot being freed this cycle is reusable only from the next cycle.
  assign disp_ready = ~&valid_vec;
  assign alloc_idx  = lowest_set(~valid_vec);
  assign accept     = disp_valid & disp_ready & ~flush;

  always_comb begin
    alloc_vec = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      alloc_vec[i] = accept && (alloc_idx == IDX_WIDTH'(i));
    end
  end

  always_comb begin
    issue_req = '0;
    for (int p = 0; p < ISSUE_NUM; p++) begin
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        issue_req[p*CIQ_DEPTH + i] = e_req[i][p];
      end
    end
  end

  // Grants on non-requesting entries are masked so they have no effect.
  assign eff_grant = grant & issue_req;

  always_comb begin
    free_vec    = '0;
    grant_cnt   = '0;
    arbit_grant = '0;
    arbit_prd   = '0;
    arbit_prd_v = '0;
    arbit_prs1  = '0;
    arbit_prs2  = '0;
    for (int p = 0; p < ISSUE_NUM; p++) begin
      arbit_grant[p] = |eff_grant[p*CIQ_DEPTH +: CIQ_DEPTH];
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        if (eff_grant[p*CIQ_DEPTH + i]) begin
          // One-hot per port: OR-ing selects the single granted entry.
          free_vec[i]                       = 1'b1;
          grant_cnt                         = grant_cnt + 1'b1;
          arbit_prd[p*PRF_WIDTH +: PRF_WIDTH]  = arbit_prd[p*PRF_WIDTH +: PRF_WIDTH]  | e_prd[i];
          arbit_prs1[p*PRF_WIDTH +: PRF_WIDTH] = arbit_prs1[p*PRF_WIDTH +: PRF_WIDTH] | e_prs1[i];
          arbit_prs2[p*PRF_WIDTH +: PRF_WIDTH] = arbit_prs2[p*PRF_WIDTH +: PRF_WIDTH] | e_prs2[i];
          arbit_prd_v[p]                    = arbit_prd_v[p] | prd_v_vec[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_WIDTH'(accept) - grant_cnt;
    end
  end

  assign ciq_count = count_q;

endmodule

// File: tb/tb_ciq_entry_array.sv
module tb_ciq_entry_array;

  localparam int NP = 4;
  localparam int W  = 6;
  localparam int D  = 16;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            disp_valid;
  logic            disp_ready;
  logic [W-1:0]    disp_prs1, disp_prs2, disp_prd;
  logic            disp_prs1_rdy, disp_prs2_rdy, disp_prd_v;
  logic [1:0]      disp_fu;
  logic [NP*W-1:0] wake_tag;
  logic [NP-1:0]   wake_valid;
  logic [NP*D-1:0] issue_req;
  logic [NP*D-1:0] grant;
  logic [NP-1:0]   arbit_grant;
  logic [NP*W-1:0] arbit_prd;
  logic [NP-1:0]   arbit_prd_v;
  logic [NP*W-1:0] arbit_prs1, arbit_prs2;
  logic [4:0]      ciq_count;

  ciq_entry_array dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prd_v(disp_prd_v), .disp_fu(disp_fu),
    .wake_tag(wake_tag), .wake_valid(wake_valid),
    .issue_req(issue_req), .grant(grant),
    .arbit_grant(arbit_grant), .arbit_prd(arbit_prd), .arbit_prd_v(arbit_prd_v),
    .arbit_prs1(arbit_prs1), .arbit_prs2(arbit_prs2),
    .ciq_count(ciq_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: an unordered pool of slots with readiness flags
  logic         m_v   [D];
  logic         m_r1  [D];
  logic         m_r2  [D];
  logic         m_pdv [D];
  logic [W-1:0] m_p1  [D];
  logic [W-1:0] m_p2  [D];
  logic [W-1:0] m_pd  [D];
  logic [1:0]   m_fu  [D];

  logic [NP*D-1:0] e_req;
  logic [NP-1:0]   e_ag, e_pdv;
  logic [NP*W-1:0] e_pd, e_p1, e_p2;
  int              e_cnt;
  logic            e_rdy;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_pdv[i] = 0;
      m_p1[i] = '0; m_p2[i] = '0; m_pd[i] = '0; m_fu[i] = '0;
    end
  endtask

  function automatic logic woke(input logic [W-1:0] t);
    for (int j = 0; j < NP; j++)
      if (wake_valid[j] && wake_tag[j*W +: W] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_req(input int p, input int i);
    return m_v[i] && m_r1[i] && m_r2[i] && (int'(m_fu[i]) == p);
  endfunction

  // expected outputs for the current model state and current inputs
  task automatic model_expect();
    e_req = '0; e_ag = '0; e_pdv = '0; e_pd = '0; e_p1 = '0; e_p2 = '0;
    e_cnt = 0; e_rdy = 0;
    for (int i = 0; i < D; i++) begin
      if (m_v[i]) e_cnt++;
      else e_rdy = 1;
    end
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < D; i++)
        if (model_req(p, i)) begin
          e_req[p*D + i] = 1'b1;
          if (grant[p*D + i]) begin
            e_ag[p] = 1'b1; e_pdv[p] = m_pdv[i];
            e_pd[p*W +: W] = m_pd[i]; e_p1[p*W +: W] = m_p1[i]; e_p2[p*W +: W] = m_p2[i];
          end
        end
  endtask

  // state update applied at every rising edge the bench drives
  task automatic model_commit();
    int   slot;
    logic freed [D];
    slot = -1;
    for (int i = 0; i < D; i++) begin
      freed[i] = 1'b0;
      if (!m_v[i] && slot < 0) slot = i;
    end
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < D; i++)
        if (grant[p*D + i] && model_req(p, i)) freed[i] = 1'b1;
    if (flush) begin
      for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      return;
    end
    for (int i = 0; i < D; i++) begin
      if (m_v[i]) begin
        if (freed[i]) m_v[i] = 1'b0;
        else begin
          if (woke(m_p1[i])) m_r1[i] = 1'b1;
          if (woke(m_p2[i])) m_r2[i] = 1'b1;
        end
      end
    end
    if (disp_valid && slot >= 0) begin
      m_v[slot]   = 1'b1;
      m_p1[slot]  = disp_prs1;
      m_p2[slot]  = disp_prs2;
      m_r1[slot]  = disp_prs1_rdy || (disp_prs1 == 0) || woke(disp_prs1);
      m_r2[slot]  = disp_prs2_rdy || (disp_prs2 == 0) || woke(disp_prs2);
      m_pd[slot]  = disp_prd;
      m_pdv[slot] = disp_prd_v;
      m_fu[slot]  = disp_fu;
    end
  endtask

  // driver tasks
  task automatic idle();
    flush = 0; disp_valid = 0; disp_prs1 = '0; disp_prs2 = '0;
    disp_prs1_rdy = 0; disp_prs2_rdy = 0; disp_prd = '0; disp_prd_v = 0;
    disp_fu = '0; wake_tag = '0; wake_valid = '0; grant = '0;
  endtask

  task automatic step_begin();
    @(negedge clk);
    idle();
  endtask

  task automatic step_end();
    @(posedge clk);
    model_commit();
  endtask

  task automatic set_disp(input int p1, input bit r1, input int p2, input bit r2,
                          input int pd, input bit pdv, input int fu);
    disp_valid = 1; disp_prs1 = W'(p1); disp_prs1_rdy = r1;
    disp_prs2 = W'(p2); disp_prs2_rdy = r2;
    disp_prd = W'(pd); disp_prd_v = pdv; disp_fu = 2'(fu);
  endtask

  task automatic set_wake(input int j, input int t);
    wake_tag[j*W +: W] = W'(t);
    wake_valid[j] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    #1;
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    total++; if (issue_req !== '0) begin bad++; $display("FAIL reset_issue_req got=%h exp=0", issue_req); end
    total++; if (arbit_grant !== '0 || arbit_prd !== '0 || arbit_prs1 !== '0 || arbit_prs2 !== '0 || arbit_prd_v !== '0)
      begin bad++; $display("FAIL reset_arbit got_grant=%b got_prd=%h exp=0", arbit_grant, arbit_prd); end
    total++; if (ciq_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ciq_count); end
    rst = 0;
  endtask

  task automatic test_wake_basic();
    logic [NP*D-1:0] exp;
    do_reset();
    step_begin(); set_disp(5, 0, 0, 0, 12, 1, 1); #1;
    total++; if (issue_req !== '0) begin bad++; $display("FAIL wake_basic_pre got=%h exp=0", issue_req); end
    step_end();
    step_begin(); set_wake(0, 5); #1;
    total++; if (ciq_count !== 5'd1) begin bad++; $display("FAIL wake_basic_count got=%0d exp=1", ciq_count); end
    total++; if (issue_req !== '0) begin bad++; $display("FAIL wake_basic_noreq got=%h exp=0", issue_req); end
    step_end();
    step_begin(); #1;
    exp = '0; exp[1*D + 0] = 1'b1;
    total++; if (issue_req !== exp) begin bad++; $display("FAIL wake_basic_req got=%h exp=%h", issue_req, exp); end
    step_end();
  endtask

  task automatic test_bypass();
    logic [NP*D-1:0] exp;
    do_reset();
    step_begin(); set_disp(7, 0, 7, 0, 33, 1, 2); set_wake(3, 7); #1; step_end();
    step_begin(); #1;
    exp = '0; exp[2*D + 0] = 1'b1;
    total++; if (issue_req !== exp) begin bad++; $display("FAIL bypass_req got=%h exp=%h", issue_req, exp); end
    step_end();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < D; i++) begin
      step_begin(); set_disp(i + 1, 1, i + 2, 1, i + 20, 1, i % 4); #1;
      total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, disp_ready); end
      step_end();
    end
    step_begin(); set_disp(1, 1, 1, 1, 55, 1, 0); #1;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", disp_ready); end
    total++; if (ciq_count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", ciq_count); end
    step_end();
    // grant entry 4 while a dispatch is still presented: slot not reusable yet
    step_begin(); grant[0*D + 4] = 1'b1; set_disp(1, 1, 1, 1, 56, 1, 0); #1;
    total++; if (ciq_count !== 5'd16) begin bad++; $display("FAIL full_ignored got=%0d exp=16", ciq_count); end
    total++; if (arbit_grant !== 4'b0001 || arbit_prd[5:0] !== 6'd24)
      begin bad++; $display("FAIL full_grant got_grant=%b got_prd=%0d exp=0001/24", arbit_grant, arbit_prd[5:0]); end
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_same_cycle_ready got=%b exp=0", disp_ready); end
    step_end();
    step_begin(); set_disp(9, 1, 9, 1, 60, 1, 3); #1;
    total++; if (disp_ready !== 1'b1 || ciq_count !== 5'd15)
      begin bad++; $display("FAIL after_grant got_ready=%b got_count=%0d exp=1/15", disp_ready, ciq_count); end
    step_end();
    step_begin(); #1;
    total++; if (issue_req[3*D + 4] !== 1'b1 || issue_req[0*D + 4] !== 1'b0 || ciq_count !== 5'd16)
      begin bad++; $display("FAIL refill_slot4 got_p3=%b got_p0=%b got_count=%0d exp=1/0/16", issue_req[3*D+4], issue_req[4], ciq_count); end
    step_end();
  endtask

  task automatic test_two_ports();
    do_reset();
    step_begin(); set_disp(1, 1, 2, 1, 10, 1, 0); #1; step_end();
    step_begin(); set_disp(3, 1, 4, 1, 11, 0, 2); #1; step_end();
    step_begin(); grant[0*D + 0] = 1'b1; grant[2*D + 1] = 1'b1; #1;
    total++; if (ciq_count !== 5'd2) begin bad++; $display("FAIL two_count_pre got=%0d exp=2", ciq_count); end
    total++; if (arbit_grant !== 4'b0101) begin bad++; $display("FAIL two_grant got=%b exp=0101", arbit_grant); end
    total++; if (arbit_prd !== {6'd0, 6'd11, 6'd0, 6'd10}) begin bad++; $display("FAIL two_prd got=%h", arbit_prd); end
    total++; if (arbit_prs1 !== {6'd0, 6'd3, 6'd0, 6'd1} || arbit_prs2 !== {6'd0, 6'd4, 6'd0, 6'd2})
      begin bad++; $display("FAIL two_prs got1=%h got2=%h", arbit_prs1, arbit_prs2); end
    total++; if (arbit_prd_v !== 4'b0001) begin bad++; $display("FAIL two_prd_v got=%b exp=0001", arbit_prd_v); end
    step_end();
    step_begin(); #1;
    total++; if (ciq_count !== 5'd0 || issue_req !== '0)
      begin bad++; $display("FAIL two_after got_count=%0d got_req=%h exp=0/0", ciq_count, issue_req); end
    step_end();
  endtask

  task automatic test_wake_invalid();
    do_reset();
    step_begin(); set_disp(9, 0, 0, 0, 40, 1, 0); #1; step_end();
    step_begin(); wake_tag[0 +: W] = 6'd9; wake_tag[2*W +: W] = 6'd9; #1; step_end();
    step_begin(); #1;
    total++; if (issue_req !== '0) begin bad++; $display("FAIL wake_invalid got=%h exp=0", issue_req); end
    set_wake(1, 9);
    step_end();
    step_begin(); #1;
    total++; if (issue_req[0] !== 1'b1) begin bad++; $display("FAIL wake_valid_later got=%b exp=1", issue_req[0]); end
    step_end();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_begin(); set_disp(0, 1, 0, 1, i, 1, i % 4); #1; step_end();
    end
    step_begin(); flush = 1; set_disp(0, 1, 0, 1, 50, 1, 0); #1;
    total++; if (ciq_count !== 5'd8) begin bad++; $display("FAIL flush_pre got=%0d exp=8", ciq_count); end
    step_end();
    step_begin(); #1;
    total++; if (ciq_count !== 5'd0 || issue_req !== '0 || disp_ready !== 1'b1)
      begin bad++; $display("FAIL flush_after got_count=%0d got_req=%h got_ready=%b exp=0/0/1", ciq_count, issue_req, disp_ready); end
    step_end();
  endtask

  task automatic test_random();
    int cand [$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step_begin();
      if ($urandom_range(0, 99) < 60)
        set_disp($urandom_range(0, 12), $urandom_range(0, 2) == 0, $urandom_range(0, 12),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 3));
      for (int j = 0; j < NP; j++) begin
        if ($urandom_range(0, 99) < 40) set_wake(j, $urandom_range(1, 12));
        else wake_tag[j*W +: W] = W'($urandom_range(1, 12));
      end
      for (int p = 0; p < NP; p++) begin
        cand.delete();
        for (int i = 0; i < D; i++) if (model_req(p, i)) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 99) < 50)
          grant[p*D + cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
        else if ($urandom_range(0, 99) < 5)
          grant[p*D + $urandom_range(0, D - 1)] = 1'b1;
      end
      if ($urandom_range(0, 99) < 3) flush = 1;
      #1;
      model_expect();
      total++; if (disp_ready !== e_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, disp_ready, e_rdy); end
      total++; if (issue_req !== e_req) begin bad++; $display("FAIL rnd_req c=%0d got=%h exp=%h", c, issue_req, e_req); end
      total++; if (arbit_grant !== e_ag) begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, arbit_grant, e_ag); end
      total++; if (arbit_prd !== e_pd || arbit_prd_v !== e_pdv)
        begin bad++; $display("FAIL rnd_prd c=%0d got=%h/%b exp=%h/%b", c, arbit_prd, arbit_prd_v, e_pd, e_pdv); end
      total++; if (arbit_prs1 !== e_p1 || arbit_prs2 !== e_p2)
        begin bad++; $display("FAIL rnd_prs c=%0d got=%h/%h exp=%h/%h", c, arbit_prs1, arbit_prs2, e_p1, e_p2); end
      total++; if (int'(ciq_count) !== e_cnt) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, ciq_count, e_cnt); end
      step_end();
    end
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    test_reset();
    test_wake_basic();
    test_bypass();
    test_full();
    test_two_ports();
    test_wake_invalid();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ciq_entry_array.md
Name: ciq_entry_array

Overview:
- Consumer end of the wake-up tag broadcast: holds CIQ_DEPTH dispatched instructions and their per-source ready bits.
- Snoops the ISSUE_NUM wake-up tag buses and sets matching ready bits.
- Raises per-port issue requests to the per-port arbiters. Frees an entry when an arbiter grants it.
- Exports the granted entry's destination tag so the wake-up logic can broadcast it.

Parameters:
- ISSUE_NUM, 4, number of issue ports / arbiters / wake-up tag buses.
- PRF_WIDTH, 6, physical register index width; index 0 is the always-ready zero register.
- CIQ_DEPTH, 16, number of queue entries.
- FU_WIDTH, 2, width of the issue-port select field; must equal clog2(ISSUE_NUM).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  invalidates all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_prs1, disp_prs2  in  PRF_WIDTH each  source physical registers.
- disp_prs1_rdy, disp_prs2_rdy  in  1 each  source already ready at rename.
- disp_prd  in  PRF_WIDTH  destination physical register.
- disp_prd_v  in  1  instruction writes a destination.
- disp_fu  in  FU_WIDTH  target issue port.
- wake_tag  in  ISSUE_NUM*PRF_WIDTH  wake-up tag buses; bus j occupies bits [j*PRF_WIDTH +: PRF_WIDTH].
- wake_valid  in  ISSUE_NUM  per-bus tag valid.
- issue_req  out  ISSUE_NUM*CIQ_DEPTH  per-port request vectors; port p occupies bits [p*CIQ_DEPTH +: CIQ_DEPTH].
- grant  in  ISSUE_NUM*CIQ_DEPTH  per-port one-hot (or zero) grant vectors, same layout as issue_req.
- arbit_grant  out  ISSUE_NUM  port p granted an entry this cycle.
- arbit_prd  out  ISSUE_NUM*PRF_WIDTH  granted entry's prd, per port.
- arbit_prd_v  out  ISSUE_NUM  granted entry's prd_v, per port.
- arbit_prs1, arbit_prs2  out  ISSUE_NUM*PRF_WIDTH each  granted entry's sources, for register read.
- ciq_count  out  clog2(CIQ_DEPTH)+1  number of valid entries.

Behaviour:
- Reset: all entry valid and ready bits cleared.
  - Outputs after reset: disp_ready=1, issue_req=0, arbit_*=0, ciq_count=0.
- Entry state, all registered: valid, prs1, prs2, r1, r2, prd, prd_v, fu.
- Allocation:
  - When disp_valid && disp_ready && !flush, write the lowest-index invalid entry at the clock edge.
  - disp_ready is combinational: OR of the invalid entries in the current registered state.
  - A slot freed by a grant in the same cycle is not reusable until the next cycle.
  - disp_valid while disp_ready=0 is ignored; no entry is written.
- Wake match:
  - Tag matches when wake_valid[j] && wake_tag[j]==src, for any j.
  - Resident entries: valid && match sets r1/r2 at the edge. Ready bits are sticky until the entry is freed.
- Dispatch-cycle bypass, applied to the entry being written:
  - r1 is set from disp_prs1_rdy OR (disp_prs1==0) OR a same-cycle wake match; likewise r2.
  - A broadcast in the dispatch cycle is never lost.
- Request:
  - issue_req[p][i] = valid_i && r1_i && r2_i && (fu_i==p).
  - Computed from registered state only, so a wake-up at edge N produces a request in cycle N+1.
- Grant handling:
  - grant must be a subset of issue_req; granting a non-requesting entry is a protocol error and has no effect.
  - For port p with a nonzero grant:
    - arbit_grant[p]=1.
    - arbit_prd/arbit_prd_v/arbit_prs1/arbit_prs2 for port p are muxed combinationally from the granted entry in the same cycle.
    - The entry's valid is cleared at the edge.
  - For port p with a zero grant: arbit_grant[p]=0 and all arbit_* fields for port p are 0. A zero tag wakes nothing harmful.
  - An entry can request on exactly one port, so multiple ports cannot grant the same entry.
- Flush: all valid bits cleared at the edge; a dispatch in the same cycle is dropped; grants still drive arbit_* that cycle.
- ciq_count: registered. Next value = count + accepted dispatch − number of granted entries; forced to 0 on flush or rst.
- Full: at CIQ_DEPTH entries, disp_ready=0. A grant in that cycle makes disp_ready=1 in the next cycle.
- Empty: issue_req=0.

Decomposition:
- Shared package (e.g. ooo_pkg):
  - constants ISSUE_NUM, PRF_WIDTH, CIQ_DEPTH, FU_WIDTH;
  - typedef for the entry struct {valid, prs1, r1, prs2, r2, prd, prd_v, fu};
  - function for the lowest-set-bit index.
- One sub-module ciq_entry:
  - holds a single entry's state;
  - does wake-up compare against all buses;
  - produces the per-port request bits.
- The top instantiates CIQ_DEPTH copies plus the allocation priority encoder, grant muxes and counter.

Test Plan:
- Reset then dispatch prs1=5 (not ready), prs2=0, fu=1 → entry 0 valid, ciq_count=1, no request. Drive wake_tag[0]=5 valid → issue_req[1][0]=1 next cycle.
- Dispatch prs1=7 (not ready), prs2=7 (not ready) while wake bus 3 carries 7 in the same cycle → entry written with r1=r2=1; request the following cycle.
- Fill 16 entries → disp_ready=0, count=16. Dispatch attempted → ignored. Grant entry 4 → next cycle disp_ready=1; next dispatch lands in entry 4.
- Two ready entries on port 0 and port 2; grant both in one cycle → arbit_grant=4'b0101, arbit_prd match the entries, count drops by 2.
- Wake bus with wake_valid=0 and tag 9 against a waiting prs1=9 → r1 stays 0, no request.
- Eight valid entries, flush asserted together with a dispatch → next cycle count=0, issue_req=0, dispatched instruction absent.
